// File: rtl/classify_scheduler.sv
// classify_scheduler
// Sequencer for the classification datapath. A free-running bin counter
// produces the bin-boundary tick; events are counted per bin period and a
// readout is launched when the period was active enough (or on host
// force_start). After readout_start the block waits for the systolic result,
// registers it for the output stage, or gives up after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   enable          bin counter runs / automatic starts allowed
//   event_strobe    one accepted compressed event this cycle
//   force_start     host request for an immediate readout
//   result_valid    systolic result strobe
//   result_class    systolic best class
//   result_pass     result qualified by score threshold
//   readout_start   one-cycle start pulse to binning + systolic
//   class_valid     one-cycle registered result strobe
//   class_pass      registered result_pass, valid with class_valid
//   class_gesture   registered result_class, held between results
//   busy            high in START or WAIT_RESULT
//   state           ARMED=0, START=1, WAIT_RESULT=2
//   window_events   event count of the last completed period
//   overrun_count   saturating count of ticks dropped while busy
//   timeout_flag    sticky result-timeout indicator
//
// Build option: define SCHED_HOLDOFF_EN to suppress the HOLDOFF_BINS ticks
// following a passing result (force_start overrides and clears the holdoff).
//
// state       | meaning
// ARMED       | idle, waiting for a qualifying tick or force_start
// START       | readout_start asserted for this single cycle
// WAIT_RESULT | waiting for result_valid, bounded by the timeout timer

module classify_scheduler #(
  parameter int CYCLES_PER_BIN = 1200000,
  parameter int MIN_EVENTS     = 20,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int EVT_BITS       = 8,
  parameter int HOLDOFF_BINS   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                event_strobe,
  input  logic                force_start,
  input  logic                result_valid,
  input  logic [1:0]          result_class,
  input  logic                result_pass,
  output logic                readout_start,
  output logic                class_valid,
  output logic                class_pass,
  output logic [1:0]          class_gesture,
  output logic                busy,
  output logic [1:0]          state,
  output logic [EVT_BITS-1:0] window_events,
  output logic [7:0]          overrun_count,
  output logic                timeout_flag
);

  localparam int BIN_W  = (CYCLES_PER_BIN > 2) ? $clog2(CYCLES_PER_BIN) : 1;
  localparam int TMR_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HOLD_W = (HOLDOFF_BINS > 1) ? $clog2(HOLDOFF_BINS + 1) : 1;

  localparam logic [BIN_W-1:0] BIN_LAST   = BIN_W'(CYCLES_PER_BIN - 1);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ARMED       = 2'd0,
    START       = 2'd1,
    WAIT_RESULT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Reset asserts asynchronously, releases on the clock edge.
  logic rst_meta, rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Bin counter and tick
  logic [BIN_W-1:0] bin_cnt;
  logic             tick;

  assign tick = enable && (bin_cnt == BIN_LAST);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      bin_cnt <= '0;
    end else if (!enable || tick) begin
      bin_cnt <= '0;
    end else begin
      bin_cnt <= bin_cnt + 1'b1;
    end
  end

  // Event counter; evt_next includes a same-cycle strobe so the tick sees it
  logic [EVT_BITS-1:0] evt_cnt, evt_next;
  logic                evt_qualify;

  assign evt_next    = (event_strobe && (evt_cnt != '1)) ? evt_cnt + 1'b1 : evt_cnt;
  assign evt_qualify = (32'(evt_next) >= 32'(MIN_EVENTS));

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      evt_cnt       <= '0;
      window_events <= '0;
    end else if (tick) begin
      window_events <= evt_next;
      evt_cnt       <= {{(EVT_BITS-1){1'b0}}, event_strobe};
    end else begin
      evt_cnt <= evt_next;
    end
  end

  // Wait timer
  logic [TMR_W-1:0] timer;
  logic             take_result, timed_out;

  assign take_result = (state_q == WAIT_RESULT) && result_valid;
  assign timed_out   = (state_q == WAIT_RESULT) && !result_valid && (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      timer <= '0;
    end else if (state_q == START) begin
      timer <= '0;
    end else if (state_q == WAIT_RESULT) begin
      timer <= timer + 1'b1;
    end
  end

  // Holdoff counter: non-zero blocks automatic starts in ARMED
  logic [HOLD_W-1:0] holdoff_cnt;
  logic              holdoff_active;

  assign holdoff_active = (holdoff_cnt != '0);

`ifdef SCHED_HOLDOFF_EN
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      holdoff_cnt <= '0;
    end else if (take_result && result_pass) begin
      holdoff_cnt <= HOLD_W'(HOLDOFF_BINS);
    end else if (state_q == ARMED && force_start) begin
      holdoff_cnt <= '0;
    end else if (state_q == ARMED && tick && holdoff_active) begin
      holdoff_cnt <= holdoff_cnt - 1'b1;
    end
  end
`else
  assign holdoff_cnt = '0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED: begin
        if (force_start) begin
          state_d = START;
        end else if (tick && evt_qualify && !holdoff_active) begin
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (result_valid || timed_out) begin
          state_d = ARMED;
        end
      end
      default: begin
        state_d = ARMED;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    readout_start = 1'b0;
    busy          = 1'b0;
    case (state_q)
      START: begin
        readout_start = 1'b1;
        busy          = 1'b1;
      end
      WAIT_RESULT: begin
        busy = 1'b1;
      end
      default: begin
        readout_start = 1'b0;
        busy          = 1'b0;
      end
    endcase
  end

  assign state = state_q;

  // Result register, overrun and timeout status
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      class_valid   <= 1'b0;
      class_pass    <= 1'b0;
      class_gesture <= 2'd0;
      overrun_count <= 8'd0;
      timeout_flag  <= 1'b0;
    end else begin
      class_valid <= take_result;
      class_pass  <= take_result && result_pass;
      if (take_result) begin
        class_gesture <= result_class;
      end
      if (tick && (state_q != ARMED) && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
      if (timed_out) begin
        timeout_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_classify_scheduler.sv
module tb_classify_scheduler;

  localparam int CPB  = 16;
  localparam int MINE = 3;
  localparam int TMO  = 40;
  localparam int EB   = 8;
  localparam int HB   = 2;
`ifdef SCHED_HOLDOFF_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          event_strobe = 1'b0;
  logic          force_start = 1'b0;
  logic          result_valid = 1'b0;
  logic [1:0]    result_class = 2'd0;
  logic          result_pass = 1'b0;
  logic          readout_start, class_valid, class_pass, busy, timeout_flag;
  logic [1:0]    class_gesture, state;
  logic [EB-1:0] window_events;
  logic [7:0]    overrun_count;

  classify_scheduler #(
    .CYCLES_PER_BIN(CPB), .MIN_EVENTS(MINE), .TIMEOUT_CYCLES(TMO),
    .EVT_BITS(EB), .HOLDOFF_BINS(HB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .event_strobe(event_strobe),
    .force_start(force_start), .result_valid(result_valid),
    .result_class(result_class), .result_pass(result_pass),
    .readout_start(readout_start), .class_valid(class_valid),
    .class_pass(class_pass), .class_gesture(class_gesture), .busy(busy),
    .state(state), .window_events(window_events),
    .overrun_count(overrun_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    logic [1:0] cls;
    logic       pass;
  } cls_exp_t;

  int       start_q[$];
  cls_exp_t cls_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every readout_start / class_valid must match the queue head.
  cls_exp_t ce;
  always @(negedge clk) begin
    if (rst_n) begin
      if (readout_start) begin
        if (start_q.size() == 0) chk("start_unexpected", cyc, 32'hFFFF_FFFF);
        else chk("start_cycle", cyc, start_q.pop_front());
      end
      if (class_valid) begin
        if (cls_q.size() == 0) chk("class_unexpected", cyc, 32'hFFFF_FFFF);
        else begin
          ce = cls_q.pop_front();
          chk("class_cycle", cyc, ce.cyc);
          chk("class_gesture", class_gesture, ce.cls);
          chk("class_pass", class_pass, ce.pass);
        end
      end
    end
  end

  // One bin period starting at count 0: nev strobes at the start, optional
  // strobe on the tick cycle, optional result_valid at offset res_at.
  task automatic period(input int nev, input bit tick_strobe, input int res_at,
                        input logic [1:0] cls, input bit pass, input bit push_cls);
    cls_exp_t e;
    for (int i = 0; i < CPB; i++) begin
      event_strobe = (i < nev) || ((i == CPB - 1) && tick_strobe);
      result_valid = (i == res_at);
      result_class = cls;
      result_pass  = pass;
      if ((i == res_at) && push_cls) begin
        e.cyc = cyc + 1; e.cls = cls; e.pass = pass;
        cls_q.push_back(e);
      end
      step();
    end
    event_strobe = 1'b0;
    result_valid = 1'b0;
    result_class = 2'd0;
    result_pass  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, readout_start, 0);
    chk({tag, "_cvalid"}, class_valid, 0);
    chk({tag, "_cpass"}, class_pass, 0);
    chk({tag, "_gesture"}, class_gesture, 0);
    chk({tag, "_window"}, window_events, 0);
    chk({tag, "_overrun"}, overrun_count, 0);
    chk({tag, "_timeout"}, timeout_flag, 0);
  endtask

  int e0, f, e1;

  initial begin
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) step();

    // Active period: 5 events, readout 16 cycles after enable
    enable = 1'b1;
    e0 = cyc;
    start_q.push_back(e0 + 16);
    period(5, 0, -1, 2'd0, 0, 0);
    chk("p0_window", window_events, 5);
    chk("p0_state_start", state, 1);
    chk("p0_busy", busy, 1);

    // Result (class 2, pass) during the period, then a skipped 2-event window
    period(1, 1, 4, 2'd2, 1, 1);
    chk("skip_window", window_events, 2);
    chk("skip_state", state, 0);
    chk("held_gesture", class_gesture, 2);

    // Tick-cycle strobe seeds the next count at 1
    period(0, 0, -1, 2'd0, 0, 0);
    chk("seed_window", window_events, 1);

    // Qualifying period, then no result: timeout with two overruns
    start_q.push_back(e0 + 64);
    period(3, 0, -1, 2'd0, 0, 0);
    chk("p3_window", window_events, 3);
    period(5, 0, -1, 2'd0, 0, 0);
    chk("ovr1_count", overrun_count, 1);
    chk("ovr1_window", window_events, 5);
    chk("ovr1_state", state, 2);
    period(0, 0, -1, 2'd0, 0, 0);
    chk("ovr2_count", overrun_count, 2);
    chk("ovr2_timeout", timeout_flag, 0);
    for (int i = 0; i < CPB; i++) begin
      if (i == 8) chk("timeout_early", timeout_flag, 0);
      if (i == 9) begin
        chk("timeout_set", timeout_flag, 1);
        chk("timeout_state", state, 0);
      end
      result_valid = (i == 10);
      result_class = 2'd3;
      result_pass  = 1'b1;
      step();
    end
    result_valid = 1'b0;
    result_pass  = 1'b0;
    result_class = 2'd0;
    chk("armed_tick_no_ovr", overrun_count, 2);
    chk("armed_window0", window_events, 0);

    // force_start with enable low; second force while busy is ignored
    enable = 1'b0;
    step();
    step();
    f = cyc;
    force_start = 1'b1;
    start_q.push_back(f + 1);
    step();
    force_start = 1'b0;
    chk("force_state", state, 1);
    step();
    step();
    force_start = 1'b1;
    step();
    force_start = 1'b0;
    result_valid = 1'b1;
    result_class = 2'd1;
    result_pass  = 1'b0;
    ce.cyc = f + 5; ce.cls = 2'd1; ce.pass = 1'b0;
    cls_q.push_back(ce);
    step();
    result_valid = 1'b0;
    result_class = 2'd0;
    step();
    step();
    chk("sticky_overrun", overrun_count, 2);
    chk("sticky_timeout", timeout_flag, 1);
    force_start = 1'b1;
    start_q.push_back(f + 8);
    step();
    force_start = 1'b0;
    step();
    step();
    step();
    chk("pre_reset_state", state, 2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();

    // Passing result followed by three qualifying periods
    enable = 1'b1;
    e1 = cyc;
    start_q.push_back(e1 + 16);
    period(4, 0, -1, 2'd0, 0, 0);
    if (!HOLD) start_q.push_back(e1 + 32);
    period(3, 0, 2, 2'd3, 1, 1);
    if (!HOLD) start_q.push_back(e1 + 48);
    period(3, 0, 3, 2'd0, 0, !HOLD);
    chk("hold_window", window_events, 3);
    start_q.push_back(e1 + 64);
    period(3, 0, 3, 2'd0, 0, !HOLD);
    chk("hold_overrun", overrun_count, 0);
    period(0, 0, 3, 2'd2, 0, 1);
    step();
    step();
    chk("start_q_empty", start_q.size(), 0);
    chk("class_q_empty", cls_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
